// File: rtl/cu_ctrl_sequencer.sv
// cu_ctrl_sequencer
//   Multi-cycle CPU control sequencer. Steps each instruction through
//   FETCH / DECODE / EXEC / MEM / WB / NEXT (or BR) and drives the control
//   bus towards PC, IR, register file, ALU and the two memories. Memory
//   accesses last MEM_WAIT+1 cycles. HALT parks the sequencer until RESET.
//   All outputs are decoded from registered state only (Moore).
//
// Ports
//   CLK            clock, rising edge
//   RESET          synchronous, active-high
//   ENABLE         run request, sampled in IDLE and at the end of NEXT/BR
//   OPCODE         opcode from IM data, captured at the end of DECODE
//   FLAGS          ALU flags, FLAGS[0]=zero, sampled in EXEC
//   RD_EN_IM       instruction memory read
//   WR_EN_IM       instruction memory write (tied low)
//   RD_EN_DM       data memory read
//   WR_EN_DM       data memory write
//   INC_PC         PC increment strobe
//   LOAD_REG       register load strobe
//   LOAD_SELECT    load target index (0=PC, 1=IR, ...)
//   ALU_OPCODE     latched opcode to ALU
//   MODE           ALU mode
//   MUX_SELECT_A   operand mux A (1=address path)
//   MUX_SELECT_B   operand mux B (1=branch offset)
//   BUSY           sequencer active (not IDLE, not HALTED)
//   HALTED         HALT executed
module cu_ctrl_sequencer #(
    parameter int unsigned OPCODE_SIZE = 5,
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned SEL_W       = $clog2(NUM_REGS),
    parameter int unsigned MEM_WAIT    = 1,
    parameter int unsigned LOAD_DST    = 2,
    parameter int unsigned ALU_DST     = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    input  logic [OPCODE_SIZE-1:0] OPCODE,
    input  logic [3:0]             FLAGS,
    output logic                   RD_EN_IM,
    output logic                   WR_EN_IM,
    output logic                   RD_EN_DM,
    output logic                   WR_EN_DM,
    output logic                   INC_PC,
    output logic                   LOAD_REG,
    output logic [SEL_W-1:0]       LOAD_SELECT,
    output logic [OPCODE_SIZE-1:0] ALU_OPCODE,
    output logic                   MODE,
    output logic                   MUX_SELECT_A,
    output logic                   MUX_SELECT_B,
    output logic                   BUSY,
    output logic                   HALTED
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_NEXT,
        S_BR,
        S_HALTED
    } state_t;

    localparam logic [1:0] CLS_ALU    = 2'b00;
    localparam logic [1:0] CLS_LOAD   = 2'b01;
    localparam logic [1:0] CLS_STORE  = 2'b10;
    localparam logic [1:0] CLS_BRANCH = 2'b11;

    localparam logic [SEL_W-1:0] SEL_PC   = '0;
    localparam logic [SEL_W-1:0] SEL_IR   = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_LOAD = SEL_W'(LOAD_DST);
    localparam logic [SEL_W-1:0] SEL_ALU  = SEL_W'(ALU_DST);
    localparam logic [3:0]       WAIT_MAX = 4'(MEM_WAIT);

    state_t                 state;
    state_t                 state_next;
    logic [OPCODE_SIZE-1:0] op_q;
    logic                   taken_q;
    logic [3:0]             wait_cnt;
    logic [1:0]             cls;
    logic                   is_halt;
    logic                   wait_done;
    logic                   unused_flags;

    assign cls          = op_q[OPCODE_SIZE-1 -: 2];
    assign is_halt      = &op_q;
    assign wait_done    = (wait_cnt == WAIT_MAX);
    assign unused_flags = ^FLAGS[3:1];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            op_q     <= '0;
            taken_q  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                op_q <= OPCODE;
            end
            if (state == S_EXEC) begin
                taken_q <= op_q[0] | FLAGS[0];
            end
            // One counter serves both memory phases; it is zero on entry
            // because every exit from FETCH/MEM happens with wait_done set.
            if ((state == S_FETCH || state == S_MEM) && !wait_done) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next   = state;
        RD_EN_IM     = 1'b0;
        WR_EN_IM     = 1'b0;
        RD_EN_DM     = 1'b0;
        WR_EN_DM     = 1'b0;
        INC_PC       = 1'b0;
        LOAD_REG     = 1'b0;
        LOAD_SELECT  = '0;
        ALU_OPCODE   = op_q;
        MODE         = 1'b0;
        MUX_SELECT_A = 1'b0;
        MUX_SELECT_B = 1'b0;
        BUSY         = 1'b1;
        HALTED       = 1'b0;

        unique case (state)
            S_IDLE: begin
                BUSY       = 1'b0;
                ALU_OPCODE = '0;
                if (ENABLE) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                RD_EN_IM = 1'b1;
                if (wait_done) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                LOAD_REG    = 1'b1;
                LOAD_SELECT = SEL_IR;
                state_next  = S_EXEC;
            end
            S_EXEC: begin
                MODE         = op_q[2];
                MUX_SELECT_A = (cls == CLS_LOAD) || (cls == CLS_STORE);
                MUX_SELECT_B = (cls == CLS_BRANCH) && !is_halt;
                if (is_halt) begin
                    state_next = S_HALTED;
                end else begin
                    unique case (cls)
                        CLS_ALU:    state_next = S_WB;
                        CLS_BRANCH: state_next = S_BR;
                        default:    state_next = S_MEM;
                    endcase
                end
            end
            S_MEM: begin
                RD_EN_DM = (cls == CLS_LOAD);
                WR_EN_DM = (cls != CLS_LOAD);
                if (wait_done) begin
                    state_next = (cls == CLS_LOAD) ? S_WB : S_NEXT;
                end
            end
            S_WB: begin
                LOAD_REG    = 1'b1;
                LOAD_SELECT = (cls == CLS_ALU) ? SEL_ALU : SEL_LOAD;
                state_next  = S_NEXT;
            end
            S_NEXT: begin
                INC_PC     = 1'b1;
                state_next = ENABLE ? S_FETCH : S_IDLE;
            end
            S_BR: begin
                // Taken branch loads the target into PC instead of stepping it.
                if (taken_q) begin
                    LOAD_REG    = 1'b1;
                    LOAD_SELECT = SEL_PC;
                end else begin
                    INC_PC = 1'b1;
                end
                state_next = ENABLE ? S_FETCH : S_IDLE;
            end
            S_HALTED: begin
                BUSY       = 1'b0;
                HALTED     = 1'b1;
                ALU_OPCODE = '0;
            end
            default: begin
                BUSY       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
